// File: rtl/vector_register_file_mt.sv
// Multithreaded lane-banked vector register file: two registered read ports, one masked write port, hardware clear engine.
// Optional same-cycle write-to-read forwarding when VECTOR_RF_BYPASS_EN is defined.
module vector_register_file_mt #(
  parameter int unsigned NUM_LANES   = 16,
  parameter int unsigned LANE_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned NUM_THREADS = 4,
  localparam int unsigned TID_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int unsigned RID_W      = $clog2(NUM_REGS),
  localparam int unsigned DATA_W     = NUM_LANES * LANE_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TID_W-1:0]  ds_thread_sel1,
  input  logic [RID_W-1:0]  ds_vector_sel1,
  input  logic [TID_W-1:0]  ds_thread_sel2,
  input  logic [RID_W-1:0]  ds_vector_sel2,
  output logic [DATA_W-1:0] rf_vector_value1,
  output logic [DATA_W-1:0] rf_vector_value2,
  input  logic              wb_enable_vector_writeback,
  input  logic [TID_W-1:0]  wb_writeback_thread,
  input  logic [RID_W-1:0]  wb_writeback_reg,
  input  logic [DATA_W-1:0] wb_writeback_value,
  input  logic [NUM_LANES-1:0] wb_writeback_mask,
  input  logic              ds_clear_request,
  input  logic [TID_W-1:0]  ds_clear_thread,
  output logic              rf_busy
);

  localparam int unsigned ROW_W = TID_W + RID_W;
  localparam int unsigned ROWS  = NUM_THREADS * NUM_REGS;

  typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_THREAD} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   end_q, end_d;
  logic               busy_q, busy_d;

  logic               clr_c;
  logic               wr_c;
  logic [ROW_W-1:0]   wr_row_c, rd1_row_c, rd2_row_c;

  // Clear engine state register; reset restarts a full-array clear from row 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_ALL;
      row_q   <= '0;
      end_q   <= ROW_W'(ROWS - 1);
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    end_d   = end_q;
    case (state_q)
      IDLE: begin
        if (ds_clear_request) begin
          state_d = CLEAR_THREAD;
          row_d   = {ds_clear_thread, {RID_W{1'b0}}};
          end_d   = {ds_clear_thread, RID_W'(NUM_REGS - 1)};
        end
      end
      CLEAR_ALL, CLEAR_THREAD: begin
        if (row_q == end_q) state_d = IDLE;
        else                row_d   = row_q + ROW_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign rf_busy   = busy_q;
  assign clr_c     = (state_q != IDLE);
  assign wr_c      = wb_enable_vector_writeback & ~clr_c;
  assign wr_row_c  = {wb_writeback_thread, wb_writeback_reg};
  assign rd1_row_c = {ds_thread_sel1, ds_vector_sel1};
  assign rd2_row_c = {ds_thread_sel2, ds_vector_sel2};

  // One independent storage bank and read-register pair per lane.
  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    logic [LANE_WIDTH-1:0] bank [ROWS];
    logic [LANE_WIDTH-1:0] wdat_c;
    logic [LANE_WIDTH-1:0] rd1_q, rd2_q;
    logic                  we_c, fwd1_c, fwd2_c;

    assign wdat_c = wb_writeback_value[i*LANE_WIDTH +: LANE_WIDTH];
    assign we_c   = wr_c & wb_writeback_mask[i];

`ifdef VECTOR_RF_BYPASS_EN
    assign fwd1_c = we_c & (rd1_row_c == wr_row_c);
    assign fwd2_c = we_c & (rd2_row_c == wr_row_c);
`else
    assign fwd1_c = 1'b0;
    assign fwd2_c = 1'b0;
`endif

    // Storage is never reset; the clear engine owns the port while active.
    always_ff @(posedge clk) begin
      if (clr_c)     bank[row_q]    <= '0;
      else if (we_c) bank[wr_row_c] <= wdat_c;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        rd1_q <= fwd1_c ? wdat_c : bank[rd1_row_c];
        rd2_q <= fwd2_c ? wdat_c : bank[rd2_row_c];
      end
    end

    assign rf_vector_value1[i*LANE_WIDTH +: LANE_WIDTH] = rd1_q;
    assign rf_vector_value2[i*LANE_WIDTH +: LANE_WIDTH] = rd2_q;
  end

endmodule
